// File: rtl/tb_seq_checker_pkg.sv
// Shared types and defaults for the receive-side sequence checker.
// The state enum is 1-bit encoded; sat_max gives the saturation value of a counter width.
package tb_chk_pkg;

    typedef enum logic [0:0] {
        CHK_ACQ   = 1'b0,
        CHK_TRACK = 1'b1
    } chk_state_t;

    localparam int CHK_DATA_WIDTH     = 8;
    localparam int CHK_CNT_WIDTH      = 16;
    localparam int CHK_ACQ_TIMEOUT    = 64;
    localparam int CHK_LOSE_LOCK_ERRS = 4;

    // All-ones value of a counter of the given width, clamped to 32 bits.
    function automatic int unsigned sat_max(input int unsigned width);
        if (width >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/tb_seq_checker_if.sv
// Stream interface between the pipeline output (master) and the sequence checker (slave).
interface tb_seq_checker_if
    import tb_chk_pkg::*;
#(
    parameter int DATA_WIDTH = CHK_DATA_WIDTH
);
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] data_i;

    modport master (output valid_i, data_i);
    modport slave  (input  valid_i, data_i);
endinterface

// File: rtl/tb_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module tb_sat_counter
    import tb_chk_pkg::*;
#(
    parameter int WIDTH = CHK_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/tb_seq_checker.sv
// Self-checker for an incrementing mod-2^DATA_WIDTH stream: locks on the first valid
// sample, counts matches/mismatches, and flags lock loss and acquisition timeout.
module tb_seq_checker
    import tb_chk_pkg::*;
#(
    parameter int DATA_WIDTH     = CHK_DATA_WIDTH,
    parameter int CNT_WIDTH      = CHK_CNT_WIDTH,
    parameter int ACQ_TIMEOUT    = CHK_ACQ_TIMEOUT,
    parameter int LOSE_LOCK_ERRS = CHK_LOSE_LOCK_ERRS
) (
    input  logic                  clk,
    input  logic                  rst,
    tb_seq_checker_if.slave       s_if,
    output logic                  locked_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] expected_o,
    output logic [CNT_WIDTH-1:0]  match_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  lost_o,
    output logic                  timeout_o
);

    localparam int TW = (ACQ_TIMEOUT > 1) ? $clog2(ACQ_TIMEOUT) : 1;
    localparam int CW = $clog2(LOSE_LOCK_ERRS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACQ_TIMEOUT - 1);
    localparam logic [CW-1:0] ERR_LIMIT  = CW'(LOSE_LOCK_ERRS);

    chk_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [TW-1:0]         r_acq_timer;
    logic [CW-1:0]         r_consec_err;
    logic                  r_err;
    logic                  r_lost;
    logic                  r_timeout;

    chk_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] w_expected_nxt;
    logic [TW-1:0]         w_timer_nxt;
    logic [CW-1:0]         w_consec_nxt;
    logic [CW-1:0]         w_consec_inc;
    logic                  w_err_nxt;
    logic                  w_lost_nxt;
    logic                  w_timeout_nxt;
    logic                  w_match_inc;
    logic                  w_err_inc;

    assign w_consec_inc = r_consec_err + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= CHK_ACQ;
            r_expected   <= '0;
            r_acq_timer  <= '0;
            r_consec_err <= '0;
            r_err        <= 1'b0;
            r_lost       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_expected   <= w_expected_nxt;
            r_acq_timer  <= w_timer_nxt;
            r_consec_err <= w_consec_nxt;
            r_err        <= w_err_nxt;
            r_lost       <= w_lost_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    // Any mismatch resyncs to data+1, so one corrupted word costs two errors.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_timer_nxt    = r_acq_timer;
        w_consec_nxt   = r_consec_err;
        w_err_nxt      = 1'b0;
        w_lost_nxt     = r_lost;
        w_timeout_nxt  = r_timeout;
        w_match_inc    = 1'b0;
        w_err_inc      = 1'b0;

        case (r_state)
            CHK_ACQ: begin
                if (s_if.valid_i) begin
                    w_expected_nxt = s_if.data_i + 1'b1;
                    w_state_nxt    = CHK_TRACK;
                    w_timer_nxt    = '0;
                end else if (r_acq_timer == TIMER_LAST) begin
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_acq_timer + 1'b1;
                end
            end
            CHK_TRACK: begin
                if (s_if.valid_i) begin
                    if (s_if.data_i == r_expected) begin
                        w_match_inc    = 1'b1;
                        w_expected_nxt = r_expected + 1'b1;
                        w_consec_nxt   = '0;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_inc      = 1'b1;
                        w_expected_nxt = s_if.data_i + 1'b1;
                        w_consec_nxt   = w_consec_inc;
                        if (w_consec_inc == ERR_LIMIT) begin
                            w_state_nxt  = CHK_ACQ;
                            w_lost_nxt   = 1'b1;
                            w_consec_nxt = '0;
                            w_timer_nxt  = '0;
                        end
                    end
                end
            end
            default: w_state_nxt = CHK_ACQ;
        endcase
    end

    tb_sat_counter #(.WIDTH(CNT_WIDTH)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_match_inc),
        .cnt (match_cnt_o)
    );

    tb_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err_inc),
        .cnt (err_cnt_o)
    );

    assign locked_o   = (r_state == CHK_TRACK);
    assign err_o      = r_err;
    assign expected_o = r_expected;
    assign lost_o     = r_lost;
    assign timeout_o  = r_timeout;

endmodule
